branch_resolve_queue: RTL and testbench

- In-order queue of in-flight branch predictions. Sits between the fetch-side predictor lookup and the execute-stage branch resolution.
- On each resolution it pops the oldest entry and drives the PHT update port (update_index, update_enable, actual_taken).
- It also flags mispredictions and keeps saturating accuracy statistics.

---
 rtl/branch_resolve_queue.sv | 131 +++++++++++++
 tb/tb_branch_resolve_queue.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - in-order branch prediction queue driving PHT updates
module branch_resolve_queue #(
  parameter int DEPTH      = 8,
  parameter int PTR_BITS   = 3,
  parameter int INDEX_BITS = 10,
  parameter int STAT_BITS  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alloc_valid,
  input  logic [INDEX_BITS-1:0] alloc_index,
  input  logic                  alloc_predicted,
  output logic                  alloc_ready,
  input  logic                  resolve_valid,
  input  logic                  resolve_taken,
  input  logic                  flush,
  output logic                  update_enable,
  output logic [INDEX_BITS-1:0] update_index,
  output logic                  actual_taken,
  output logic                  mispredict,
  output logic                  resolve_error,
  output logic [PTR_BITS:0]     count,
  output logic [STAT_BITS-1:0]  resolved_count,
  output logic [STAT_BITS-1:0]  mispredict_count
);

  localparam logic [PTR_BITS:0] FULL_COUNT = (PTR_BITS+1)'(DEPTH);

  // entry layout: {index, predicted}
  logic [INDEX_BITS:0] entry_q [DEPTH];

  logic [PTR_BITS-1:0]   head_q, head_d, tail_q, tail_d;
  logic [PTR_BITS:0]     count_q, count_d;
  logic                  update_enable_q, update_enable_d;
  logic [INDEX_BITS-1:0] update_index_q, update_index_d;
  logic                  actual_taken_q, actual_taken_d;
  logic                  mispredict_q, mispredict_d;
  logic                  resolve_error_q, resolve_error_d;
  logic [STAT_BITS-1:0]  resolved_q, resolved_d;
  logic [STAT_BITS-1:0]  mispredicted_q, mispredicted_d;

  logic                  wr_en;
  logic [INDEX_BITS:0]   wr_data;
  logic                  non_empty, do_resolve, do_alloc, wrong_path, clear_all;
  logic [INDEX_BITS-1:0] head_index;
  logic                  head_pred;

  assign alloc_ready = (count_q != FULL_COUNT);

  // next-state: resolve the head first, then either discard everything or enqueue
  always_comb begin
    non_empty  = (count_q != '0);
    head_index = entry_q[head_q][INDEX_BITS:1];
    head_pred  = entry_q[head_q][0];
    do_resolve = resolve_valid && non_empty;
    wrong_path = do_resolve && (head_pred != resolve_taken);
    clear_all  = flush || wrong_path;
    // an allocation on a flushed or mispredicted cycle belongs to the wrong path
    do_alloc   = alloc_valid && alloc_ready && !clear_all;
    wr_en      = do_alloc;
    wr_data    = {alloc_index, alloc_predicted};

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_all) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_BITS'(do_resolve);
      tail_d  = tail_q + PTR_BITS'(do_alloc);
      count_d = count_q + (PTR_BITS+1)'(do_alloc) - (PTR_BITS+1)'(do_resolve);
    end

    update_enable_d = do_resolve;
    update_index_d  = do_resolve ? head_index : '0;
    actual_taken_d  = do_resolve && resolve_taken;
    mispredict_d    = wrong_path;
    resolve_error_d = resolve_valid && !non_empty;

    resolved_d     = resolved_q;
    mispredicted_d = mispredicted_q;
    if (do_resolve && (resolved_q != '1))
      resolved_d = resolved_q + STAT_BITS'(1);
    if (wrong_path && (mispredicted_q != '1))
      mispredicted_d = mispredicted_q + STAT_BITS'(1);
  end

  // control, output and statistics registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      update_enable_q <= 1'b0;
      update_index_q  <= '0;
      actual_taken_q  <= 1'b0;
      mispredict_q    <= 1'b0;
      resolve_error_q <= 1'b0;
      resolved_q      <= '0;
      mispredicted_q  <= '0;
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      update_enable_q <= update_enable_d;
      update_index_q  <= update_index_d;
      actual_taken_q  <= actual_taken_d;
      mispredict_q    <= mispredict_d;
      resolve_error_q <= resolve_error_d;
      resolved_q      <= resolved_d;
      mispredicted_q  <= mispredicted_d;
    end
  end

  // entry storage; contents are don't-care until written, so no reset
  always_ff @(posedge clock) begin
    if (wr_en)
      entry_q[tail_q] <= wr_data;
  end

  assign update_enable    = update_enable_q;
  assign update_index     = update_index_q;
  assign actual_taken     = actual_taken_q;
  assign mispredict       = mispredict_q;
  assign resolve_error    = resolve_error_q;
  assign count            = count_q;
  assign resolved_count   = resolved_q;
  assign mispredict_count = mispredicted_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb/tb_branch_resolve_queue.sv - randomized and directed bench for branch_resolve_queue
module tb_branch_resolve_queue;

  typedef struct {
    logic [9:0] idx;
    logic       pred;
  } entry_t;

  logic        clock, reset;
  logic        alloc_valid, alloc_predicted, alloc_ready;
  logic [9:0]  alloc_index;
  logic        resolve_valid, resolve_taken, flush;
  logic        update_enable, actual_taken, mispredict, resolve_error;
  logic [9:0]  update_index;
  logic [3:0]  count;
  logic [15:0] resolved_count, mispredict_count;

  int checks = 0;
  int errors = 0;

  // reference model state
  entry_t q[$];
  int     m_res, m_mis;
  logic   e_ue, e_at, e_mis, e_err;
  logic [9:0] e_idx;

  branch_resolve_queue dut (
    .clock(clock), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_index(alloc_index),
    .alloc_predicted(alloc_predicted), .alloc_ready(alloc_ready),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .flush(flush),
    .update_enable(update_enable), .update_index(update_index),
    .actual_taken(actual_taken), .mispredict(mispredict),
    .resolve_error(resolve_error), .count(count),
    .resolved_count(resolved_count), .mispredict_count(mispredict_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_res = 0; m_mis = 0;
    e_ue = 0; e_idx = 0; e_at = 0; e_mis = 0; e_err = 0;
  endtask

  // one clock: drive, check pre-edge state, advance model, check registered outputs
  task automatic cycle(input logic av, input logic [9:0] ai, input logic ap,
                       input logic rv, input logic rt, input logic fl);
    int     sz;
    entry_t h, n;
    alloc_valid = av; alloc_index = ai; alloc_predicted = ap;
    resolve_valid = rv; resolve_taken = rt; flush = fl;
    check("alloc_ready", alloc_ready, 32'(q.size() != 8));
    check("count", count, q.size());
    @(posedge clock);
    sz = q.size();
    e_ue = 0; e_idx = 0; e_at = 0; e_mis = 0; e_err = 0;
    if (rv && sz == 0) e_err = 1;
    if (rv && sz > 0) begin
      h = q.pop_front();
      e_ue = 1; e_idx = h.idx; e_at = rt; e_mis = (h.pred != rt);
      if (m_res < 65535) m_res++;
      if (e_mis && m_mis < 65535) m_mis++;
    end
    if (fl || e_mis) q.delete();
    else if (av && sz != 8) begin
      n.idx = ai; n.pred = ap;
      q.push_back(n);
    end
    #1;
    check("update_enable", update_enable, e_ue);
    check("update_index", update_index, e_idx);
    check("actual_taken", actual_taken, e_at);
    check("mispredict", mispredict, e_mis);
    check("resolve_error", resolve_error, e_err);
    check("resolved_count", resolved_count, m_res);
    check("mispredict_count", mispredict_count, m_mis);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  // asynchronous reset asserted between edges, held over an edge, then released
  task automatic do_reset();
    reset = 1'b1;
    alloc_valid = 0; resolve_valid = 0; flush = 0; alloc_index = 0;
    alloc_predicted = 0; resolve_taken = 0;
    #1;
    check("rst_count", count, 0);
    check("rst_ready", alloc_ready, 1);
    check("rst_ue", update_enable, 0);
    check("rst_idx", update_index, 0);
    check("rst_at", actual_taken, 0);
    check("rst_mis", mispredict, 0);
    check("rst_err", resolve_error, 0);
    check("rst_res", resolved_count, 0);
    check("rst_misc", mispredict_count, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    reset = 1'b1;
    alloc_valid = 0; alloc_index = 0; alloc_predicted = 0;
    resolve_valid = 0; resolve_taken = 0; flush = 0;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    do_reset();

    // basic update
    cycle(1, 10'h155, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 0);
    check("basic_ue", update_enable, 1);
    check("basic_idx", update_index, 10'h155);
    check("basic_cnt", count, 0);
    check("basic_res", resolved_count, 1);
    idle();

    // fill, overflow attempt, drain, wrap
    for (int i = 0; i < 8; i++) cycle(1, 10'(i), 0, 0, 0, 0);
    check("full_ready", alloc_ready, 0);
    check("full_cnt", count, 8);
    cycle(1, 10'h3aa, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 0, 1, 0, 0);
      check("drain_idx", update_index, i);
    end
    for (int i = 0; i < 4; i++) cycle(1, 10'(16 + i), 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 1, 0, 0);
      check("wrap_idx", update_index, 16 + i);
    end
    idle();

    // mispredict flush
    do_reset();
    cycle(1, 10'h010, 0, 0, 0, 0);
    cycle(1, 10'h020, 0, 0, 0, 0);
    cycle(1, 10'h030, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 0);
    check("mp_mis", mispredict, 1);
    check("mp_idx", update_index, 10'h010);
    check("mp_cnt", count, 0);
    check("mp_misc", mispredict_count, 1);
    cycle(0, 0, 0, 1, 1, 0);
    check("mp_err", resolve_error, 1);
    check("mp_noupd", update_enable, 0);

    // external flush with same-cycle resolve and alloc
    for (int i = 0; i < 3; i++) cycle(1, 10'(10'h100 + i), 1, 0, 0, 0);
    cycle(1, 10'h3ff, 1, 1, 1, 1);
    check("fl_ue", update_enable, 1);
    check("fl_idx", update_index, 10'h100);
    check("fl_cnt", count, 0);
    idle();

    // simultaneous alloc + resolve at count 4
    for (int i = 0; i < 4; i++) cycle(1, 10'(10'h200 + i), 1, 0, 0, 0);
    cycle(1, 10'h2ff, 1, 1, 1, 0);
    check("sim_cnt", count, 4);
    check("sim_idx", update_index, 10'h200);
    idle();

    // randomized traffic, resolve direction biased toward the stored prediction
    for (int n = 0; n < 600; n++) begin
      logic av, rv, rt, fl;
      av = ($urandom_range(0, 9) < 7);
      rv = ($urandom_range(0, 9) < 4);
      fl = ($urandom_range(0, 99) < 3);
      if (q.size() > 0 && $urandom_range(0, 9) != 0) rt = q[0].pred;
      else rt = 1'($urandom);
      cycle(av, 10'($urandom), 1'($urandom), rv, rt, fl);
    end

    // reset mid-stream
    for (int i = 0; i < 5; i++) cycle(1, 10'(10'h050 + i), 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) idle();

    // statistics saturation
    cycle(1, 10'h077, 1, 0, 0, 0);
    for (int i = 0; i < 65536; i++) cycle(1, 10'h077, 1, 1, 1, 0);
    check("sat_res", resolved_count, 16'hffff);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
